mod_counter_ld: RTL and testbench

MOD_COUNTER_LD -- requirements
Module: mod_counter_ld

---
 rtl/counter_pkg.sv | 18 +
 rtl/mod_counter_ld_if.sv | 25 ++
 rtl/mod_counter_next.sv | 76 +++++++
 rtl/mod_counter_ld.sv | 67 ++++++
 tb/tb_mod_counter_ld.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the modulo counter family: overflow-policy encodings
// and the elaboration-time parameter legality check.
package counter_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // The modulus may span the full 2^WIDTH range, so the bound is evaluated in 64 bits.
    function automatic bit params_ok(input int width, input int modulus,
                                     input int rst_val, input int mode);
        longint span;
        span = longint'(1) << width;
        return (width >= 1) && (modulus >= 2) && (longint'(modulus) <= span) &&
               (rst_val >= 0) && (rst_val < modulus) &&
               ((mode == MODE_WRAP) || (mode == MODE_SAT));
    endfunction

endpackage

// File: rtl/mod_counter_ld_if.sv
// Control/status bundle of the loadable modulo counter; the master drives the
// controls, the counter (slave) returns the count and its flags.
interface mod_counter_ld_if #(
    parameter int WIDTH = 5
);
    logic             en;
    logic             up_dn;
    logic             clr;
    logic             ld;
    logic [WIDTH-1:0] ld_val;
    logic [WIDTH-1:0] out;
    logic             tc;
    logic             wrap;
    logic             sat;

    modport master (
        output en, up_dn, clr, ld, ld_val,
        input  out, tc, wrap, sat
    );

    modport slave (
        input  en, up_dn, clr, ld, ld_val,
        output out, tc, wrap, sat
    );
endinterface

// File: rtl/mod_counter_next.sv
// Combinational next-value selection for mod_counter_ld: clear, clamped load,
// up/down step with wrap or saturating hold. Holds no state.
module mod_counter_next
    import counter_pkg::*;
#(
    parameter int WIDTH    = 5,
    parameter int MOD      = 32,
    parameter int SATURATE = MODE_WRAP,
    parameter int RST_VAL  = 0
) (
    input  logic [WIDTH-1:0] cur,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] nxt,
    output logic             wrap_evt,
    output logic             sat_evt,
    output logic             flags_clr
);
    // One extra bit keeps MOD = 2^WIDTH representable so the limit compare cannot alias.
    localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH+1)'(MOD);
    localparam logic [WIDTH:0]   LIMIT_EXT = (WIDTH+1)'(MOD - 1);
    localparam logic [WIDTH-1:0] LIMIT     = WIDTH'(MOD - 1);
    localparam logic [WIDTH-1:0] CLR_VAL   = WIDTH'(RST_VAL);
    localparam bit               SAT_MODE  = (SATURATE == MODE_SAT);

    logic [WIDTH:0] cur_ext;
    logic [WIDTH:0] ld_ext;

    assign cur_ext = {1'b0, cur};
    assign ld_ext  = {1'b0, ld_val};

    // NOTE: every output gets a default before any branch so no latch is inferred.
    always_comb begin
        nxt       = cur;
        wrap_evt  = 1'b0;
        sat_evt   = 1'b0;
        flags_clr = 1'b0;

        if (clr) begin
            nxt       = CLR_VAL;
            flags_clr = 1'b1;
        end else if (ld) begin
            nxt       = (ld_ext < MOD_EXT) ? ld_val : LIMIT;
            flags_clr = 1'b1;
        end else if (en) begin
            if (up_dn) begin
                if (cur_ext >= LIMIT_EXT) begin
                    if (SAT_MODE) begin
                        nxt     = LIMIT;
                        sat_evt = 1'b1;
                    end else begin
                        nxt      = '0;
                        wrap_evt = 1'b1;
                    end
                end else begin
                    nxt = WIDTH'(cur_ext + (WIDTH+1)'(1));
                end
            end else begin
                if (cur == '0) begin
                    if (SAT_MODE) begin
                        nxt     = '0;
                        sat_evt = 1'b1;
                    end else begin
                        nxt      = LIMIT;
                        wrap_evt = 1'b1;
                    end
                end else begin
                    nxt = WIDTH'(cur_ext - (WIDTH+1)'(1));
                end
            end
        end
    end
endmodule

// File: rtl/mod_counter_ld.sv
// Loadable up/down modulo counter with wrap or saturate policy, registered
// wrap pulse and sticky saturation flag, and a combinational cascade tc.
module mod_counter_ld
    import counter_pkg::*;
#(
    parameter int WIDTH    = 5,
    parameter int MOD      = 32,
    parameter int SATURATE = MODE_WRAP,
    parameter int RST_VAL  = 0
) (
    input  logic            clk,
    input  logic            RST,
    mod_counter_ld_if.slave bus
);
    localparam logic [WIDTH-1:0] LIMIT     = WIDTH'(MOD - 1);
    localparam logic [WIDTH-1:0] RESET_VAL = WIDTH'(RST_VAL);

    if (!params_ok(WIDTH, MOD, RST_VAL, SATURATE)) begin : g_param_check
        $error("mod_counter_ld: illegal WIDTH/MOD/RST_VAL/SATURATE combination");
    end

    logic [WIDTH-1:0] out_q;
    logic             wrap_q;
    logic             sat_q;
    logic [WIDTH-1:0] nxt;
    logic             wrap_evt;
    logic             sat_evt;
    logic             flags_clr;

    mod_counter_next #(
        .WIDTH    (WIDTH),
        .MOD      (MOD),
        .SATURATE (SATURATE),
        .RST_VAL  (RST_VAL)
    ) u_next (
        .cur       (out_q),
        .en        (bus.en),
        .up_dn     (bus.up_dn),
        .clr       (bus.clr),
        .ld        (bus.ld),
        .ld_val    (bus.ld_val),
        .nxt       (nxt),
        .wrap_evt  (wrap_evt),
        .sat_evt   (sat_evt),
        .flags_clr (flags_clr)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (RST) begin
            out_q  <= RESET_VAL;
            wrap_q <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            out_q  <= nxt;
            wrap_q <= wrap_evt;
            sat_q  <= flags_clr ? 1'b0 : (sat_q | sat_evt);
        end
    end

    // Terminal count is unregistered so a cascaded stage can step on the same edge.
    assign bus.tc   = bus.en & ((bus.up_dn & (out_q == LIMIT)) |
                                (~bus.up_dn & (out_q == '0)));
    assign bus.out  = out_q;
    assign bus.wrap = wrap_q;
    assign bus.sat  = sat_q;
endmodule

// File: tb/tb_mod_counter_ld.sv
// Directed bench for mod_counter_ld: four instances cover wrap mode, saturate
// mode, a non-zero reset value and the full 2^WIDTH modulus.
module tb_mod_counter_ld;
    import counter_pkg::*;

    logic clk;
    logic rst_a, rst_b, rst_c, rst_d;
    int   n_pass;
    int   n_total;

    mod_counter_ld_if #(.WIDTH(5)) ia ();
    mod_counter_ld_if #(.WIDTH(5)) ib ();
    mod_counter_ld_if #(.WIDTH(5)) ic ();
    mod_counter_ld_if #(.WIDTH(5)) id ();

    mod_counter_ld #(.WIDTH(5), .MOD(20), .SATURATE(MODE_WRAP), .RST_VAL(0))
        u_a (.clk(clk), .RST(rst_a), .bus(ia.slave));
    mod_counter_ld #(.WIDTH(5), .MOD(20), .SATURATE(MODE_SAT), .RST_VAL(0))
        u_b (.clk(clk), .RST(rst_b), .bus(ib.slave));
    mod_counter_ld #(.WIDTH(5), .MOD(20), .SATURATE(MODE_WRAP), .RST_VAL(7))
        u_c (.clk(clk), .RST(rst_c), .bus(ic.slave));
    mod_counter_ld #(.WIDTH(5), .MOD(32), .SATURATE(MODE_WRAP), .RST_VAL(0))
        u_d (.clk(clk), .RST(rst_d), .bus(id.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [7:0] got, want;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;
        ia.en = 1'b1; ia.up_dn = 1'b1; ia.ld = 1'b1; ia.ld_val = 5'd9;
        tick;
        tick;
        ia.ld = 1'b0;
        #1;
        got = {ia.out, ia.tc, ia.wrap, ia.sat}; want = {5'd0, 3'b000};
        n_total++;
        if (got !== want) $display("FAIL reset_a: out|tc|wrap|sat got %b want %b", got, want);
        else n_pass++;
        ia.up_dn = 1'b0;
        #1;
        got = {ia.out, ia.tc, ia.wrap, ia.sat}; want = {5'd0, 3'b100};
        n_total++;
        if (got !== want) $display("FAIL reset_tc_down: out|tc|wrap|sat got %b want %b", got, want);
        else n_pass++;
        got = {ic.out, ic.tc, ic.wrap, ic.sat}; want = {5'd7, 3'b000};
        n_total++;
        if (got !== want) $display("FAIL reset_c_rstval: out|tc|wrap|sat got %b want %b", got, want);
        else n_pass++;
        got = {ib.out, ib.sat, id.out, id.wrap}; want = {5'd0, 1'b0, 5'd0, 1'b0};
        n_total++;
        if (got !== want) $display("FAIL reset_b_d: b.out|b.sat|d.out|d.wrap got %b want %b", got, want);
        else n_pass++;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
        ia.en = 1'b0; ia.up_dn = 1'b1;
    endtask

    task automatic test_up_wrap;
        logic [7:0] got, want;
        ia.en = 1'b1; ia.up_dn = 1'b1;
        #1;
        for (int i = 0; i <= 21; i++) begin
            got  = {ia.out, ia.tc, ia.wrap, ia.sat};
            want = {5'(i % 20), (i == 19), (i == 20), 1'b0};
            n_total++;
            if (got !== want) $display("FAIL up_wrap[%0d]: out|tc|wrap|sat got %b want %b", i, got, want);
            else n_pass++;
            if (i < 21) tick;
        end
        ia.en = 1'b0;
        tick;
        tick;
        got = {ia.out, ia.tc, ia.wrap, ia.sat}; want = {5'd1, 3'b000};
        n_total++;
        if (got !== want) $display("FAIL hold_idle: out|tc|wrap|sat got %b want %b", got, want);
        else n_pass++;
    endtask

    task automatic test_down;
        logic [7:0] got, want;
        ia.ld = 1'b1; ia.ld_val = 5'd1;
        tick;
        ia.ld = 1'b0; ia.en = 1'b1; ia.up_dn = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            got = {ia.out, ia.tc, ia.wrap, ia.sat};
            case (i)
                0:       want = {5'd1,  3'b000};
                1:       want = {5'd0,  3'b100};
                2:       want = {5'd19, 3'b010};
                default: want = {5'd18, 3'b000};
            endcase
            n_total++;
            if (got !== want) $display("FAIL down[%0d]: out|tc|wrap|sat got %b want %b", i, got, want);
            else n_pass++;
            if (i < 3) tick;
        end
        ia.en = 1'b0; ia.up_dn = 1'b1;
    endtask

    task automatic test_load_clamp;
        logic [7:0] got, want;
        ia.ld = 1'b1; ia.ld_val = 5'd25;
        tick;
        got = {ia.out, ia.tc, ia.wrap, ia.sat}; want = {5'd19, 3'b000};
        n_total++;
        if (got !== want) $display("FAIL ld_clamp_25: out|tc|wrap|sat got %b want %b", got, want);
        else n_pass++;
        ia.ld_val = 5'd20;
        tick;
        n_total++;
        if (ia.out !== 5'd19) $display("FAIL ld_clamp_20: out got %0d want 19", ia.out);
        else n_pass++;
        // From 19 an up step would wrap; the load must win and suppress the pulse.
        ia.ld_val = 5'd3; ia.en = 1'b1; ia.up_dn = 1'b1;
        tick;
        got = {ia.out, ia.tc, ia.wrap, ia.sat}; want = {5'd3, 3'b000};
        n_total++;
        if (got !== want) $display("FAIL ld_over_en: out|tc|wrap|sat got %b want %b", got, want);
        else n_pass++;
        ia.ld_val = 5'd5; ia.clr = 1'b1;
        tick;
        ia.clr = 1'b0; ia.en = 1'b0;
        ia.ld_val = 5'd19;
        #1;
        n_total++;
        if (ia.out !== 5'd0) $display("FAIL clr_over_ld: out got %0d want 0", ia.out);
        else n_pass++;
        tick;
        ia.ld = 1'b0; ia.en = 1'b1;
        tick;
        got = {ia.out, ia.tc, ia.wrap, ia.sat}; want = {5'd0, 3'b010};
        n_total++;
        if (got !== want) $display("FAIL wrap_before_clr: out|tc|wrap|sat got %b want %b", got, want);
        else n_pass++;
        ia.clr = 1'b1;
        tick;
        ia.clr = 1'b0; ia.en = 1'b0;
        #1;
        got = {ia.out, ia.tc, ia.wrap, ia.sat}; want = {5'd0, 3'b000};
        n_total++;
        if (got !== want) $display("FAIL clr_kills_wrap: out|tc|wrap|sat got %b want %b", got, want);
        else n_pass++;
    endtask

    task automatic test_saturate;
        logic [7:0] got, want;
        ib.ld = 1'b1; ib.ld_val = 5'd18;
        tick;
        ib.ld = 1'b0; ib.en = 1'b1; ib.up_dn = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            got = {ib.out, ib.tc, ib.wrap, ib.sat};
            case (i)
                0:       want = {5'd18, 3'b000};
                1:       want = {5'd19, 3'b100};
                default: want = {5'd19, 3'b101};
            endcase
            n_total++;
            if (got !== want) $display("FAIL sat_up[%0d]: out|tc|wrap|sat got %b want %b", i, got, want);
            else n_pass++;
            if (i < 3) tick;
        end
        ib.en = 1'b0; ib.clr = 1'b1;
        tick;
        ib.clr = 1'b0;
        #1;
        got = {ib.out, ib.tc, ib.wrap, ib.sat}; want = {5'd0, 3'b000};
        n_total++;
        if (got !== want) $display("FAIL sat_clr: out|tc|wrap|sat got %b want %b", got, want);
        else n_pass++;
        ib.en = 1'b1; ib.up_dn = 1'b0;
        tick;
        ib.en = 1'b0;
        tick;
        got = {ib.out, ib.tc, ib.wrap, ib.sat}; want = {5'd0, 3'b001};
        n_total++;
        if (got !== want) $display("FAIL sat_down_sticky: out|tc|wrap|sat got %b want %b", got, want);
        else n_pass++;
        ib.ld = 1'b1; ib.ld_val = 5'd4;
        tick;
        ib.ld = 1'b0; ib.up_dn = 1'b1;
        #1;
        got = {ib.out, ib.tc, ib.wrap, ib.sat}; want = {5'd4, 3'b000};
        n_total++;
        if (got !== want) $display("FAIL sat_ld_clears: out|tc|wrap|sat got %b want %b", got, want);
        else n_pass++;
    endtask

    task automatic test_rst_mid;
        logic [7:0] got, want;
        ia.ld = 1'b1; ia.ld_val = 5'd12;
        tick;
        ia.ld = 1'b0; ia.en = 1'b1; ia.up_dn = 1'b1; rst_a = 1'b1;
        tick;
        rst_a = 1'b0; ia.en = 1'b0;
        #1;
        got = {ia.out, ia.tc, ia.wrap, ia.sat}; want = {5'd0, 3'b000};
        n_total++;
        if (got !== want) $display("FAIL rst_mid_a: out|tc|wrap|sat got %b want %b", got, want);
        else n_pass++;
        ic.en = 1'b1; ic.up_dn = 1'b1;
        for (int i = 0; i < 5; i++) tick;
        n_total++;
        if (ic.out !== 5'd12) $display("FAIL c_count_to_12: out got %0d want 12", ic.out);
        else n_pass++;
        rst_c = 1'b1;
        tick;
        got = {ic.out, ic.tc, ic.wrap, ic.sat}; want = {5'd7, 3'b000};
        n_total++;
        if (got !== want) $display("FAIL rst_mid_c: out|tc|wrap|sat got %b want %b", got, want);
        else n_pass++;
        rst_c = 1'b0; ic.en = 1'b0; ic.ld = 1'b1; ic.ld_val = 5'd19;
        tick;
        ic.ld = 1'b0; ic.en = 1'b1;
        tick;
        got = {ic.out, ic.tc, ic.wrap, ic.sat}; want = {5'd0, 3'b010};
        n_total++;
        if (got !== want) $display("FAIL c_wrap_to_zero: out|tc|wrap|sat got %b want %b", got, want);
        else n_pass++;
        rst_c = 1'b1;
        tick;
        rst_c = 1'b0; ic.en = 1'b0; ic.clr = 1'b1;
        #1;
        got = {ic.out, ic.tc, ic.wrap, ic.sat}; want = {5'd7, 3'b000};
        n_total++;
        if (got !== want) $display("FAIL rst_kills_wrap_c: out|tc|wrap|sat got %b want %b", got, want);
        else n_pass++;
        ic.ld = 1'b1; ic.ld_val = 5'd2;
        tick;
        ic.ld = 1'b0;
        tick;
        ic.clr = 1'b0;
        n_total++;
        if (ic.out !== 5'd7) $display("FAIL c_clr_to_rstval: out got %0d want 7", ic.out);
        else n_pass++;
    endtask

    task automatic test_full_range;
        logic [7:0] got, want;
        id.ld = 1'b1; id.ld_val = 5'd31;
        tick;
        id.ld = 1'b0; id.en = 1'b1; id.up_dn = 1'b1;
        #1;
        got = {id.out, id.tc, id.wrap, id.sat}; want = {5'd31, 3'b100};
        n_total++;
        if (got !== want) $display("FAIL full_at_31: out|tc|wrap|sat got %b want %b", got, want);
        else n_pass++;
        tick;
        got = {id.out, id.tc, id.wrap, id.sat}; want = {5'd0, 3'b010};
        n_total++;
        if (got !== want) $display("FAIL full_wrap_up: out|tc|wrap|sat got %b want %b", got, want);
        else n_pass++;
        tick;
        id.up_dn = 1'b0;
        tick;
        got = {id.out, id.tc, id.wrap, id.sat}; want = {5'd0, 3'b100};
        n_total++;
        if (got !== want) $display("FAIL full_down_to_0: out|tc|wrap|sat got %b want %b", got, want);
        else n_pass++;
        tick;
        got = {id.out, id.tc, id.wrap, id.sat}; want = {5'd31, 3'b010};
        n_total++;
        if (got !== want) $display("FAIL full_wrap_down: out|tc|wrap|sat got %b want %b", got, want);
        else n_pass++;
        id.en = 1'b0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;
        ia.en = 1'b0; ia.up_dn = 1'b1; ia.clr = 1'b0; ia.ld = 1'b0; ia.ld_val = '0;
        ib.en = 1'b0; ib.up_dn = 1'b1; ib.clr = 1'b0; ib.ld = 1'b0; ib.ld_val = '0;
        ic.en = 1'b0; ic.up_dn = 1'b1; ic.clr = 1'b0; ic.ld = 1'b0; ic.ld_val = '0;
        id.en = 1'b0; id.up_dn = 1'b1; id.clr = 1'b0; id.ld = 1'b0; id.ld_val = '0;

        test_reset;
        test_up_wrap;
        test_down;
        test_load_clamp;
        test_saturate;
        test_rst_mid;
        test_full_range;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
